// File: rtl/qam_iq_demod_pkg.sv
// Shared types and helpers for the QPSK/16QAM coherent demodulator.
package qam_pkg;

    localparam int SYM_W = 4;

    localparam logic MOD_QPSK  = 1'b0;
    localparam logic MOD_16QAM = 1'b1;

    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } sync_state_t;

    // Q1.31 x Q1.31 mixer product, keeping bits [62:31] of the full product.
    function automatic logic signed [31:0] mul_q31(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        return 32'((64'(a) * 64'(b)) >>> 31);
    endfunction

endpackage

// File: rtl/qam_iq_demod_if.sv
// Sample stream into the demodulator and payload symbol stream out of it.
interface qam_iq_demod_if;
    import qam_pkg::*;

    // Handshake: sample_valid and sym_valid are single-cycle strobes with no
    // back-pressure; the data fields are meaningful only in a strobed cycle.
    logic              sample_valid;
    logic signed [31:0] rx_iq;
    logic signed [31:0] carrier_i;
    logic signed [31:0] carrier_q;
    logic [SYM_W-1:0]  sym_data;
    logic              sym_valid;

    modport master (
        output sample_valid, rx_iq, carrier_i, carrier_q,
        input  sym_data, sym_valid
    );

    modport slave (
        input  sample_valid, rx_iq, carrier_i, carrier_q,
        output sym_data, sym_valid
    );

endinterface

// File: rtl/qam_iq_demod_slicer.sv
// Per-axis hard decision: sign bit plus optional inner/outer bit for 16QAM.
module qam_slicer (
    input  logic signed [31:0] n,
    input  logic signed [31:0] thr,
    input  logic               qam16,
    output logic [1:0]         bits
);

    logic signed [32:0] n_ext;
    logic signed [32:0] mag;

    // One extra bit so the magnitude of the most negative value stays positive.
    assign n_ext   = 33'(n);
    assign mag     = n[31] ? -n_ext : n_ext;
    assign bits[1] = n[31];
    assign bits[0] = qam16 && (mag < 33'(thr));

endmodule

// File: rtl/qam_iq_demod.sv
// Coherent I/Q demodulator: mixer, integrate-and-dump, slicer and pilot frame sync.
// Build option QAM_DEMOD_SAT_EN: saturating accumulators and normalisation instead of wrap.
module qam_iq_demod
    import qam_pkg::*;
#(
    parameter int               BASE_SPS     = 64,
    parameter int               ACC_W        = 44,
    parameter int               PILOT_PERIOD = 16,
    parameter logic [SYM_W-1:0] PILOT_SYM    = 4'h0,
    parameter int               MAX_MISS     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mod_type,
    input  logic [1:0]         baud_rate,
    input  logic signed [31:0] slice_thr,
    qam_iq_demod_if.slave      bus,
    output logic               locked,
    output logic signed [31:0] sym_i,
    output logic signed [31:0] sym_q,
    output sync_state_t        sync_state
);

    localparam int CNT_W   = $clog2(BASE_SPS * 8);
    localparam int SLOT_W  = $clog2(PILOT_PERIOD);
    localparam int MISS_W  = $clog2(MAX_MISS + 1);
    localparam int LOG_SPS = $clog2(BASE_SPS);

    logic                     cfg_mod;
    logic [1:0]               cfg_baud;
    logic                     cfg_change;
    logic [CNT_W-1:0]         last_cnt;
    logic [3:0]               norm_sh;
    logic                     p_vld;
    logic signed [31:0]       p_i, p_q;
    logic signed [ACC_W-1:0]  acc_i, acc_q, dump_i, dump_q;
    logic                     dump_vld;
    logic [CNT_W-1:0]         cnt;
    logic signed [31:0]       n_i, n_q;
    logic [1:0]               bits_i, bits_q;
    logic [SYM_W-1:0]         code;
    logic                     is_pilot;
    logic                     is_16qam;
    sync_state_t              state;
    logic [SLOT_W-1:0]        slot, slot_nxt;
    logic [MISS_W-1:0]        miss;

    function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [31:0] b);
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
`ifdef QAM_DEMOD_SAT_EN
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
        return s[ACC_W-1:0];
    endfunction

    // Mode/rate are compared against last cycle's copy; any difference flushes the datapath.
    assign cfg_change = (mod_type != cfg_mod) || (baud_rate != cfg_baud);
    assign last_cnt   = CNT_W'((BASE_SPS << (int'(BAUD_19200) - int'(cfg_baud))) - 1);
    assign norm_sh    = 4'(LOG_SPS + int'(BAUD_19200) - int'(cfg_baud));
    assign is_16qam   = (cfg_mod == MOD_16QAM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_mod  <= MOD_QPSK;
            cfg_baud <= BAUD_2400;
            p_vld    <= 1'b0;
            p_i      <= '0;
            p_q      <= '0;
            acc_i    <= '0;
            acc_q    <= '0;
            dump_i   <= '0;
            dump_q   <= '0;
            dump_vld <= 1'b0;
            cnt      <= '0;
        end else begin
            cfg_mod  <= mod_type;
            cfg_baud <= baud_rate;
            if (cfg_change) begin
                p_vld    <= 1'b0;
                dump_vld <= 1'b0;
                acc_i    <= '0;
                acc_q    <= '0;
                cnt      <= '0;
            end else begin
                p_vld    <= bus.sample_valid;
                dump_vld <= 1'b0;
                if (bus.sample_valid) begin
                    p_i <= mul_q31(bus.rx_iq, bus.carrier_i);
                    p_q <= mul_q31(bus.rx_iq, bus.carrier_q);
                end
                if (p_vld) begin
                    if (cnt == last_cnt) begin
                        dump_i   <= acc_add(acc_i, p_i);
                        dump_q   <= acc_add(acc_q, p_q);
                        acc_i    <= '0;
                        acc_q    <= '0;
                        cnt      <= '0;
                        dump_vld <= 1'b1;
                    end else begin
                        acc_i <= acc_add(acc_i, p_i);
                        acc_q <= acc_add(acc_q, p_q);
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

`ifdef QAM_DEMOD_SAT_EN
    function automatic logic signed [31:0] sat32(input logic signed [ACC_W-1:0] x);
        if ((&x[ACC_W-1:31]) || !(|x[ACC_W-1:31]))
            return x[31:0];
        return x[ACC_W-1] ? 32'sh8000_0000 : 32'sh7fff_ffff;
    endfunction

    assign n_i = sat32(dump_i >>> norm_sh);
    assign n_q = sat32(dump_q >>> norm_sh);
`else
    assign n_i = 32'(dump_i >>> norm_sh);
    assign n_q = 32'(dump_q >>> norm_sh);
`endif

    qam_slicer u_slice_i (.n(n_i), .thr(slice_thr), .qam16(is_16qam), .bits(bits_i));
    qam_slicer u_slice_q (.n(n_q), .thr(slice_thr), .qam16(is_16qam), .bits(bits_q));

    assign code       = {bits_i, bits_q};
    assign is_pilot   = (code == PILOT_SYM);
    assign slot_nxt   = (slot == SLOT_W'(PILOT_PERIOD - 1)) ? '0 : slot + SLOT_W'(1);
    assign sync_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SEARCH;
            slot          <= '0;
            miss          <= '0;
            locked        <= 1'b0;
            bus.sym_valid <= 1'b0;
            bus.sym_data  <= '0;
            sym_i         <= '0;
            sym_q         <= '0;
        end else if (cfg_change) begin
            state         <= SEARCH;
            slot          <= '0;
            miss          <= '0;
            locked        <= 1'b0;
            bus.sym_valid <= 1'b0;
        end else begin
            bus.sym_valid <= 1'b0;
            if (dump_vld) begin
                sym_i <= n_i;
                sym_q <= n_q;
                case (state)
                    SEARCH: begin
                        if (is_pilot) begin
                            state <= VERIFY;
                            slot  <= SLOT_W'(1);
                        end
                    end
                    VERIFY: begin
                        if (slot != '0) begin
                            slot <= slot_nxt;
                        end else if (is_pilot) begin
                            state  <= LOCK;
                            locked <= 1'b1;
                            slot   <= slot_nxt;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                    LOCK: begin
                        slot <= slot_nxt;
                        if (slot != '0) begin
                            bus.sym_valid <= 1'b1;
                            bus.sym_data  <= code;
                        end else if (is_pilot) begin
                            miss <= '0;
                        end else if (miss >= MISS_W'(MAX_MISS - 1)) begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                            miss   <= '0;
                            slot   <= '0;
                        end else begin
                            miss <= miss + MISS_W'(1);
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qam_iq_demod.sv
// Randomised bench for qam_iq_demod against a symbol-level reference model.
module tb_qam_iq_demod;
    import qam_pkg::*;

    localparam int OUTER = 1610612736;  // 0.75 full scale
    localparam int INNER = 536870912;   // 0.25 full scale

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               mod_type = 1'b0;
    logic [1:0]         baud_rate = 2'b11;
    logic signed [31:0] slice_thr = 32'sd0;
    logic               locked;
    logic signed [31:0] sym_i, sym_q;
    sync_state_t        sync_state;

    qam_iq_demod_if bus ();

    qam_iq_demod dut (
        .clk        (clk),
        .rst        (rst),
        .mod_type   (mod_type),
        .baud_rate  (baud_rate),
        .slice_thr  (slice_thr),
        .bus        (bus),
        .locked     (locked),
        .sym_i      (sym_i),
        .sym_q      (sym_q),
        .sync_state (sync_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_emit = 0;
    logic [3:0] exp_q[$];

    // reference model state
    longint m_acc_i, m_acc_q;
    int     m_cnt, m_state, m_slot, m_miss;
    int     m_ni, m_nq;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint wrap44(input longint x);
        return (x <<< 20) >>> 20;
    endfunction

    function automatic int q31(input int a, input int b);
        longint m;
        m = longint'(a) * longint'(b);
        return int'(m >>> 31);
    endfunction

    function automatic logic [1:0] slice_ax(input int n);
        longint mag;
        mag = (n < 0) ? -longint'(n) : longint'(n);
        return {n < 0, mod_type && (mag < longint'(slice_thr))};
    endfunction

    function automatic sync_state_t state_of(input int s);
        case (s)
            1: return VERIFY;
            2: return LOCK;
            default: return SEARCH;
        endcase
    endfunction

    task automatic model_flush();
        m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
        m_state = 0; m_slot = 0; m_miss = 0;
    endtask

    // Frame sync at symbol granularity: slot 0 of each frame must hold the pilot.
    task automatic model_sync(input logic [3:0] code, output bit emit);
        bit pilot;
        pilot = (code == 4'h0);
        emit = 1'b0;
        if (m_state == 0) begin
            if (pilot) begin m_state = 1; m_slot = 1; end
        end else if (m_state == 1) begin
            if (m_slot != 0) m_slot = (m_slot + 1) % 16;
            else if (pilot) begin m_state = 2; m_slot = 1; end
            else m_state = 0;
        end else begin
            if (m_slot != 0) begin
                emit = 1'b1;
                m_slot = (m_slot + 1) % 16;
            end else begin
                m_slot = 1;
                if (pilot) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_miss >= 3) begin m_state = 0; m_slot = 0; m_miss = 0; end
                end
            end
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (bus.sym_valid === 1'b1) begin
            n_emit++;
            if (exp_q.size() == 0) check("spurious_sym_valid", 1, 0);
            else check("sym_data", bus.sym_data, exp_q.pop_front());
        end
    end

    // driver: one sample, with an occasional idle gap in front of it
    task automatic drive_sample(input int rx, input int ci, input int cq);
        int sh, sps, pi, pq;
        longint di, dq;
        bit emit;
        logic [3:0] code;
        if ($urandom_range(0, 9) == 0)
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        bus.rx_iq = rx; bus.carrier_i = ci; bus.carrier_q = cq;
        bus.sample_valid = 1'b1;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        sh  = 9 - int'(baud_rate);
        sps = 1 << sh;
        pi  = q31(rx, ci);
        pq  = q31(rx, cq);
        m_cnt++;
        if (m_cnt < sps) begin
            m_acc_i = wrap44(m_acc_i + pi);
            m_acc_q = wrap44(m_acc_q + pq);
        end else begin
            di = wrap44(m_acc_i + pi);
            dq = wrap44(m_acc_q + pq);
            m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
            m_ni = int'(di >>> sh);
            m_nq = int'(dq >>> sh);
            code = {slice_ax(m_ni), slice_ax(m_nq)};
            model_sync(code, emit);
            if (emit) exp_q.push_back(code);
            repeat (2) @(posedge clk);
            #1;
            check("sym_i", sym_i, m_ni);
            check("sym_q", sym_q, m_nq);
            check("locked", locked, m_state == 2);
            check("sym_valid", bus.sym_valid, emit);
            check("sync_state", sync_state, state_of(m_state));
            @(posedge clk); #1;
        end
    endtask

    function automatic int level(input logic [1:0] b);
        int l;
        l = (b[0] && mod_type) ? INNER : OUTER;
        return b[1] ? -l : l;
    endfunction

    task automatic send_symbol(input logic [3:0] code, input int nsamp);
        int rx, ci, cq;
        for (int i = 0; i < nsamp; i++) begin
            rx = 2147483647 - int'($urandom_range(0, 1 << 20));
            ci = level(code[3:2]) + int'($urandom_range(0, 1 << 22)) - (1 << 21);
            cq = level(code[1:0]) + int'($urandom_range(0, 1 << 22)) - (1 << 21);
            drive_sample(rx, ci, cq);
        end
    endtask

    function automatic logic [3:0] rand_payload();
        return 4'($urandom_range(1, 15));
    endfunction

    function automatic int sps_now();
        return 64 << (3 - int'(baud_rate));
    endfunction

    task automatic send_frame(input bit pilot, input int exp_emits);
        int base;
        base = n_emit;
        send_symbol(pilot ? 4'h0 : rand_payload(), sps_now());
        for (int s = 1; s < 16; s++) send_symbol(rand_payload(), sps_now());
        check("frame_emits", n_emit - base, exp_emits);
    endtask

    task automatic set_cfg(input logic m, input logic [1:0] b);
        mod_type = m;
        baud_rate = b;
        repeat (2) @(posedge clk);
        #1;
        model_flush();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_i;
        bus.sample_valid = 1'b0;
        bus.rx_iq = 0; bus.carrier_i = 0; bus.carrier_q = 0;
        model_flush();
        m_ni = 0; m_nq = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sym_data", bus.sym_data, 0);
        check("rst_sym_valid", bus.sym_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_sym_i", sym_i, 0);
        check("rst_sym_q", sym_q, 0);
        check("rst_state", sync_state, SEARCH);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // QPSK 19200 Bd, rx = 0.5 * carrier_i, carrier_q = 0
        for (int i = 0; i < 64; i++) drive_sample(759250125, 1518500250, 0);
        check("qpsk_i_quarter_fs", (sym_i > 515396075) && (sym_i < 558345748), 1);
        check("qpsk_q_zero", sym_q, 0);
        for (int k = 0; k < 3; k++) send_symbol(rand_payload(), 64);

        // 16QAM, threshold 0.5 FS: acquire, hold through 2 misses, drop after 3
        slice_thr = 32'sd1073741824;
        set_cfg(1'b1, 2'b11);
        send_frame(1'b1, 0);
        send_frame(1'b1, 15);
        check("locked_after_2nd_pilot", locked, 1);
        send_frame(1'b1, 15);
        send_frame(1'b0, 15);
        send_frame(1'b0, 15);
        send_frame(1'b1, 15);
        check("lock_kept_2_miss", locked, 1);
        send_frame(1'b0, 15);
        send_frame(1'b0, 15);
        send_frame(1'b0, 0);
        check("lock_lost_3_miss", locked, 0);
        send_frame(1'b1, 0);
        send_frame(1'b1, 15);

        // baud switch mid-symbol while locked
        send_symbol(4'h0, 64);
        send_symbol(rand_payload(), 30);
        set_cfg(1'b1, 2'b00);
        check("switch_unlocked", locked, 0);
        check("switch_search", sync_state, SEARCH);
        prev_i = m_ni;
        send_symbol(4'h5, 511);
        repeat (3) @(posedge clk);
        #1;
        check("switch_no_dump_511", sym_i, prev_i);
        send_symbol(4'h5, 1);

        // reset mid-frame while locked
        set_cfg(1'b1, 2'b11);
        send_frame(1'b1, 0);
        send_frame(1'b1, 15);
        send_symbol(4'h0, 64);
        send_symbol(rand_payload(), 20);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_sym_data", bus.sym_data, 0);
        check("midrst_sym_valid", bus.sym_valid, 0);
        check("midrst_locked", locked, 0);
        check("midrst_sym_i", sym_i, 0);
        check("midrst_sym_q", sym_q, 0);
        rst = 1'b0;
        model_flush();
        repeat (3) @(posedge clk);
        #1;
        send_frame(1'b1, 0);
        check("post_rst_unlocked", locked, 0);

        check("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
